scramble_frame_scheduler: RTL and testbench



---
 rtl/scramble_frame_scheduler.sv | 242 ++++++++++++++++++++++++
 tb/tb_scramble_frame_scheduler.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/scramble_frame_scheduler.sv
// scramble_frame_scheduler
// Frame-level sequencer for the video scrambler. It drives frame_sync,
// enable and key_byte from the pixel timing, and it defers key changes and
// enable/disable requests to frame boundaries. This keeps the transmit and
// receive LFSRs in step.
//
// Optional feature macro: SCR_KEY_ROTATE_EN
//   defined   - the key rotates automatically every KEY_PERIOD completed frames
//   undefined - the key changes only through the key-load handshake
module scramble_frame_scheduler #(
    parameter int unsigned H_ACTIVE   = 320,
    parameter int unsigned V_ACTIVE   = 240,
    parameter int unsigned KEY_PERIOD = 4,
    parameter logic [7:0]  SEED       = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       pixel_valid,
    input  logic       scramble_en,
    input  logic       key_load_req,
    input  logic [7:0] key_load_value,
    output logic       key_load_ack,
    output logic       scr_frame_sync,
    output logic       scr_enable,
    output logic [7:0] scr_key_byte,
    output logic [7:0] frame_count,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned     PIX_TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int unsigned     PIX_W     = $clog2(PIX_TOTAL + 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_TOTAL);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [PIX_W-1:0] pix_inc_s;
    logic             sync_q, sync_d;
    logic             enable_q, enable_d;
    logic [7:0]       key_q, key_d;
    logic             ack_q, ack_d;
    logic [7:0]       fcnt_q, fcnt_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             pend_full_q, pend_full_d;
    logic [7:0]       pend_key_q, pend_key_d;
    logic             boundary_s;

`ifdef SCR_KEY_ROTATE_EN
    localparam int unsigned     ROT_W   = (KEY_PERIOD < 2) ? 1 : $clog2(KEY_PERIOD + 1);
    localparam logic [ROT_W-1:0] ROT_MAX = ROT_W'(KEY_PERIOD);

    logic [ROT_W-1:0] rot_q, rot_d;

    // One step of the key LFSR: shift left, with the tap feedback entering at bit 0
    function automatic logic [7:0] next_key(input logic [7:0] k);
        return {k[6:0], k[7] ^ k[5] ^ k[4] ^ k[3]};
    endfunction
`endif

    assign pix_inc_s = pix_cnt_q + PIX_W'(1);

    // Next-state, boundary and handshake logic; all outputs are computed here and registered below
    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        sync_d      = 1'b0;
        enable_d    = 1'b0;
        key_d       = key_q;
        ack_d       = 1'b0;
        fcnt_d      = fcnt_q;
        err_d       = err_q;
        pend_full_d = pend_full_q;
        pend_key_d  = pend_key_q;
        boundary_s  = 1'b0;
`ifdef SCR_KEY_ROTATE_EN
        rot_d       = rot_q;
`endif

        case (state_q)
            IDLE: begin
                if (scramble_en) begin
                    state_d = ARMED;
                end else begin
                    state_d = IDLE;
                end
            end
            ARMED: begin
                // Dropping the request while armed takes effect at once,
                // because no frame is in flight yet.
                if (!scramble_en) begin
                    state_d = IDLE;
                end else if (frame_start) begin
                    boundary_s = 1'b1;
                    state_d    = ACTIVE;
                end else begin
                    state_d = ARMED;
                end
            end
            ACTIVE: begin
                if (frame_start) begin
                    // A short frame is flagged and does not count as completed.
                    // A pixel coincident with frame_start is ignored.
                    err_d = 1'b1;
                    if (scramble_en) begin
                        boundary_s = 1'b1;
                        state_d    = ACTIVE;
                    end else begin
                        pix_cnt_d = {PIX_W{1'b0}};
                        state_d   = IDLE;
                    end
                end else if (pixel_valid) begin
                    enable_d  = 1'b1;
                    pix_cnt_d = pix_inc_s;
                    if (pix_inc_s == PIX_LAST) begin
                        state_d = FLUSH;
                    end else begin
                        state_d = ACTIVE;
                    end
                end else begin
                    state_d = ACTIVE;
                end
            end
            FLUSH: begin
                if (frame_start) begin
                    fcnt_d = fcnt_q + 8'd1;
`ifdef SCR_KEY_ROTATE_EN
                    if (rot_q != ROT_MAX) begin
                        rot_d = rot_q + ROT_W'(1);
                    end else begin
                        rot_d = rot_q;
                    end
`endif
                    if (scramble_en) begin
                        boundary_s = 1'b1;
                        state_d    = ACTIVE;
                    end else begin
                        pix_cnt_d = {PIX_W{1'b0}};
                        state_d   = IDLE;
                    end
                end else if (pixel_valid) begin
                    // This is an overflow pixel. It is not scrambled.
                    err_d   = 1'b1;
                    state_d = FLUSH;
                end else begin
                    state_d = FLUSH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Frame boundary: emit a sync pulse, update the key and restart the pixel count
        if (boundary_s) begin
            sync_d    = 1'b1;
            pix_cnt_d = {PIX_W{1'b0}};
            if (pend_full_q) begin
                key_d       = pend_key_q;
                pend_full_d = 1'b0;
`ifdef SCR_KEY_ROTATE_EN
                rot_d       = {ROT_W{1'b0}};
            end else if (rot_d == ROT_MAX) begin
                key_d = next_key(key_q);
                rot_d = {ROT_W{1'b0}};
`endif
            end else begin
                key_d = key_q;
            end
        end else begin
            sync_d = 1'b0;
        end

        // Key-load handshake: accept a new key only when the pending slot is free
        if (key_load_req && !pend_full_q) begin
            pend_key_d  = key_load_value;
            pend_full_d = 1'b1;
            ack_d       = 1'b1;
        end else begin
            ack_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers with asynchronous reset to the idle and seed values
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pix_cnt_q   <= {PIX_W{1'b0}};
            sync_q      <= 1'b0;
            enable_q    <= 1'b0;
            key_q       <= SEED;
            ack_q       <= 1'b0;
            fcnt_q      <= 8'd0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            pend_full_q <= 1'b0;
            pend_key_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            sync_q      <= sync_d;
            enable_q    <= enable_d;
            key_q       <= key_d;
            ack_q       <= ack_d;
            fcnt_q      <= fcnt_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            pend_full_q <= pend_full_d;
            pend_key_q  <= pend_key_d;
        end
    end

`ifdef SCR_KEY_ROTATE_EN
    // Counter of completed frames since the last key change
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rot_q <= {ROT_W{1'b0}};
        end else begin
            rot_q <= rot_d;
        end
    end
`endif

    assign key_load_ack   = ack_q;
    assign scr_frame_sync = sync_q;
    assign scr_enable     = enable_q;
    assign scr_key_byte   = key_q;
    assign frame_count    = fcnt_q;
    assign frame_err      = err_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_scramble_frame_scheduler.sv
// Directed testbench for scramble_frame_scheduler (H=4, V=2, KEY_PERIOD=2).
// Works with or without SCR_KEY_ROTATE_EN defined.
module tb_scramble_frame_scheduler;

    logic       clk;
    logic       reset;
    logic       frame_start;
    logic       pixel_valid;
    logic       scramble_en;
    logic       key_load_req;
    logic [7:0] key_load_value;
    logic       key_load_ack;
    logic       scr_frame_sync;
    logic       scr_enable;
    logic [7:0] scr_key_byte;
    logic [7:0] frame_count;
    logic       frame_err;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    // The key after two completed frames from A5 is {0100101, 1^1^0^0} = 8'h4A.
`ifdef SCR_KEY_ROTATE_EN
    localparam logic [7:0] K1 = 8'h4A;
`else
    localparam logic [7:0] K1 = 8'hA5;
`endif

    scramble_frame_scheduler #(
        .H_ACTIVE  (4),
        .V_ACTIVE  (2),
        .KEY_PERIOD(2),
        .SEED      (8'hA5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .pixel_valid   (pixel_valid),
        .scramble_en   (scramble_en),
        .key_load_req  (key_load_req),
        .key_load_value(key_load_value),
        .key_load_ack  (key_load_ack),
        .scr_frame_sync(scr_frame_sync),
        .scr_enable    (scr_enable),
        .scr_key_byte  (scr_key_byte),
        .frame_count   (frame_count),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       fs, pv, en, kr;
        logic [7:0] kv;
        logic       sync, eno;
        logic [7:0] key;
        logic       ack;
        logic [7:0] fc;
        logic       err, busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic fs, pv, en, kr, input logic [7:0] kv,
                       input logic sync, eno, input logic [7:0] key,
                       input logic ack, input logic [7:0] fc, input logic err, busy);
        vec_t v;
        v.fs = fs; v.pv = pv; v.en = en; v.kr = kr; v.kv = kv;
        v.sync = sync; v.eno = eno; v.key = key; v.ack = ack;
        v.fc = fc; v.err = err; v.busy = busy;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic sync, eno, input logic [7:0] key,
                           input logic ack, input logic [7:0] fc, input logic err, bsy);
        chk("frame_sync", idx, 32'(scr_frame_sync), 32'(sync));
        chk("enable",     idx, 32'(scr_enable),     32'(eno));
        chk("key_byte",   idx, 32'(scr_key_byte),   32'(key));
        chk("ack",        idx, 32'(key_load_ack),   32'(ack));
        chk("frame_count",idx, 32'(frame_count),    32'(fc));
        chk("frame_err",  idx, 32'(frame_err),      32'(err));
        chk("busy",       idx, 32'(busy),           32'(bsy));
    endtask

    task automatic drive(input logic fs, pv, en, kr, input logic [7:0] kv);
        frame_start = fs; pixel_valid = pv; scramble_en = en;
        key_load_req = kr; key_load_value = kv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        frame_start = 1'b0; pixel_valid = 1'b0; scramble_en = 1'b0;
        key_load_req = 1'b0; key_load_value = 8'd0;

        // Columns: fs pv en kr kv | sync en key ack fc err busy
        add(1'b0,1'b0,1'b1,1'b0,8'h00, 1'b0,1'b0,8'hA5,1'b0,8'd0,1'b0,1'b1); // armed
        add(1'b1,1'b0,1'b1,1'b0,8'h00, 1'b1,1'b0,8'hA5,1'b0,8'd0,1'b0,1'b1); // first boundary
        for (int i = 0; i < 8; i++)
            add(1'b0,1'b1,1'b1,1'b0,8'h00, 1'b0,1'b1,8'hA5,1'b0,8'd0,1'b0,1'b1);
        add(1'b1,1'b0,1'b1,1'b0,8'h00, 1'b1,1'b0,8'hA5,1'b0,8'd1,1'b0,1'b1); // frame 1 done
        for (int i = 0; i < 8; i++)
            add(1'b0,1'b1,1'b1,1'b0,8'h00, 1'b0,1'b1,8'hA5,1'b0,8'd1,1'b0,1'b1);
        add(1'b0,1'b1,1'b1,1'b0,8'h00, 1'b0,1'b0,8'hA5,1'b0,8'd1,1'b1,1'b1); // 9th pixel overflow
        add(1'b1,1'b0,1'b1,1'b0,8'h00, 1'b1,1'b0,K1,  1'b0,8'd2,1'b1,1'b1); // frame 2 done, rotation point
        for (int i = 0; i < 3; i++)
            add(1'b0,1'b1,1'b1,1'b0,8'h00, 1'b0,1'b1,K1,1'b0,8'd2,1'b1,1'b1);
        add(1'b1,1'b1,1'b1,1'b0,8'h00, 1'b1,1'b0,K1,  1'b0,8'd2,1'b1,1'b1); // short frame, pixel ignored
        for (int i = 0; i < 2; i++)
            add(1'b0,1'b1,1'b1,1'b0,8'h00, 1'b0,1'b1,K1,1'b0,8'd2,1'b1,1'b1);
        add(1'b0,1'b1,1'b1,1'b1,8'h3C, 1'b0,1'b1,K1,  1'b1,8'd2,1'b1,1'b1); // key load acked
        for (int i = 0; i < 5; i++)                                           // second req held
            add(1'b0,1'b1,1'b1,1'b1,8'h55, 1'b0,1'b1,K1,1'b0,8'd2,1'b1,1'b1);
        add(1'b1,1'b0,1'b1,1'b1,8'h55, 1'b1,1'b0,8'h3C,1'b0,8'd3,1'b1,1'b1); // pending key applied
        add(1'b0,1'b0,1'b1,1'b1,8'h55, 1'b0,1'b0,8'h3C,1'b1,8'd3,1'b1,1'b1); // second req now acked
        add(1'b0,1'b0,1'b1,1'b0,8'h00, 1'b0,1'b0,8'h3C,1'b0,8'd3,1'b1,1'b1);
        for (int i = 0; i < 3; i++)
            add(1'b0,1'b1,1'b1,1'b0,8'h00, 1'b0,1'b1,8'h3C,1'b0,8'd3,1'b1,1'b1);
        for (int i = 0; i < 5; i++)                                           // enable dropped
            add(1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,1'b1,8'h3C,1'b0,8'd3,1'b1,1'b1);
        add(1'b1,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,8'h3C,1'b0,8'd4,1'b1,1'b0); // to IDLE, no sync
        add(1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,8'h3C,1'b0,8'd4,1'b1,1'b0);
        add(1'b0,1'b0,1'b1,1'b0,8'h00, 1'b0,1'b0,8'h3C,1'b0,8'd4,1'b1,1'b1);
        add(1'b1,1'b0,1'b1,1'b0,8'h00, 1'b1,1'b0,8'h55,1'b0,8'd4,1'b1,1'b1); // pending 55 applied

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all(-1, 1'b0, 1'b0, 8'hA5, 1'b0, 8'd0, 1'b0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].fs, tbl[i].pv, tbl[i].en, tbl[i].kr, tbl[i].kv);
            chk_all(i, tbl[i].sync, tbl[i].eno, tbl[i].key, tbl[i].ack,
                    tbl[i].fc, tbl[i].err, tbl[i].busy);
        end

        // Mid-frame reset: the key captured here must be discarded
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h77);
        chk("ack_before_reset", 100, 32'(key_load_ack), 32'd1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("enable_before_reset", 101, 32'(scr_enable), 32'd1);
        reset = 1'b1;
        #1;
        chk_all(102, 1'b0, 1'b0, 8'hA5, 1'b0, 8'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // The armed state falls back to idle as soon as scramble_en drops
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("busy_armed", 103, 32'(busy), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("busy_disarmed", 104, 32'(busy), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("sync_after_reset", 105, 32'(scr_frame_sync), 32'd1);
        chk("key_after_reset",  105, 32'(scr_key_byte),   32'hA5);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("sync_one_cycle", 106, 32'(scr_frame_sync), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
